// File: rtl/fix2flt_seq_if.sv
// Control and byte-memory bus of the fixed-to-float converter.
interface fix2flt_seq_if;
  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;

  modport master (
    output start, mem_rd_data,
    input  done, busy, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  start, mem_rd_data,
    output done, busy, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/fix2flt_seq.sv
// Sequential 16-bit sign-magnitude to half-float converter working through a byte memory.
// It reads two source bytes, normalizes one bit per cycle, and writes the two result bytes.
module fix2flt_seq #(
  parameter logic [7:0] SRC_LO_ADDR = 8'd0,
  parameter logic [7:0] SRC_HI_ADDR = 8'd1,
  parameter logic [7:0] DST_LO_ADDR = 8'd2,
  parameter logic [7:0] DST_HI_ADDR = 8'd3,
  parameter logic [4:0] EXP_INIT    = 5'd21
) (
  input logic          clk,
  input logic          reset,
  fix2flt_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, NORM, WR_LO, WR_HI, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  in_hi;
  logic [14:0] mag;
  logic [4:0]  exp;
  logic        sign;
  logic [15:0] result;

  // A zero magnitude is never shifted, so it alone selects the signed-zero result.
  assign result = (mag == '0) ? {sign, 15'b0} : {sign, exp, mag[13:4]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_hi <= '0;
      mag   <= '0;
      exp   <= '0;
      sign  <= 1'b0;
    end else begin
      case (state)
        RD_HI: in_hi <= bus.mem_rd_data;
        RD_LO: begin
          sign <= in_hi[7];
          mag  <= {in_hi[6:0], bus.mem_rd_data};
          exp  <= EXP_INIT;
        end
        NORM: begin
          if (mag != '0 && !mag[14]) begin
            mag <= {mag[13:0], 1'b0};
            exp <= exp - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = RD_HI;
      end
      RD_HI: begin
        bus.mem_addr = SRC_HI_ADDR;
        state_nxt    = RD_LO;
      end
      RD_LO: begin
        bus.mem_addr = SRC_LO_ADDR;
        state_nxt    = NORM;
      end
      NORM: begin
        if (mag == '0 || mag[14]) state_nxt = WR_LO;
      end
      WR_LO: begin
        bus.mem_addr    = DST_LO_ADDR;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = result[7:0];
        state_nxt       = WR_HI;
      end
      WR_HI: begin
        bus.mem_addr    = DST_HI_ADDR;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = result[15:8];
        state_nxt       = DONE;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        if (bus.start) state_nxt = RD_HI;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fix2flt_seq.sv
// Directed and random checks of fix2flt_seq against hand-computed half-float results.
module tb_fix2flt_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fix2flt_seq_if bus();

  fix2flt_seq #(
    .SRC_LO_ADDR(8'd0),
    .SRC_HI_ADDR(8'd1),
    .DST_LO_ADDR(8'd2),
    .DST_HI_ADDR(8'd3),
    .EXP_INIT   (5'd21)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [0:255];
  int         wr_cnt;
  int         n_tests;
  int         n_fail;

  assign bus.mem_rd_data = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [15:0] in;
    logic [15:0] res;
    int          edges;
    int          repulse;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: count leading zeros of the 15-bit magnitude, then normalize.
  function automatic void model(input logic [15:0] in, output logic [15:0] res, output int edges);
    logic [14:0] m;
    int          k;
    m = in[14:0];
    k = 0;
    if (m == 15'd0) begin
      res   = {in[15], 15'd0};
      edges = 6;
    end else begin
      while (m[14] == 1'b0) begin
        m = m << 1;
        k++;
      end
      res   = {in[15], 5'(21 - k), m[13:4]};
      edges = k + 6;
    end
  endfunction

  task automatic run_conv(input logic [15:0] in, input int repulse,
                          output logic [15:0] res, output int edges, output int pulses);
    mem[0] = in[7:0];
    mem[1] = in[15:8];
    mem[2] = 8'h5a;
    mem[3] = 8'ha5;
    @(negedge clk);
    wr_cnt    = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 1;
    while (!bus.done && edges < 40) begin
      bus.start = (edges == repulse);
      @(posedge clk);
      #1;
      edges++;
    end
    bus.start = 1'b0;
    res    = {mem[3], mem[2]};
    pulses = wr_cnt;
  endtask

  vec_t        vecs [8];
  logic [15:0] res, mres;
  int          edges, medges, pulses;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    wr_cnt    = 0;
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = '{16'h7fff, 16'h57ff,  6, 0};
    vecs[1] = '{16'h0001, 16'h1c00, 20, 0};
    vecs[2] = '{16'h8000, 16'h8000,  6, 0};
    vecs[3] = '{16'h8003, 16'ha200, 19, 0};
    vecs[4] = '{16'hc000, 16'hd400,  6, 0};
    vecs[5] = '{16'h0000, 16'h0000,  6, 0};
    vecs[6] = '{16'h1234, 16'h4c8d,  8, 0};
    vecs[7] = '{16'h0003, 16'h2200, 19, 5};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",    32'(bus.done),        32'd0);
    check("rst_busy",    32'(bus.busy),        32'd0);
    check("rst_wr_en",   32'(bus.mem_wr_en),   32'd0);
    check("rst_addr",    32'(bus.mem_addr),    32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_conv(vecs[i].in, vecs[i].repulse, res, edges, pulses);
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_edges", i), 32'(edges), 32'(vecs[i].edges));
      check($sformatf("vec%0d_wr_pulses", i), 32'(pulses), 32'd2);
    end

    // Done must stay high and the bus idle while parked in DONE.
    repeat (3) @(posedge clk);
    #1;
    check("done_held", 32'(bus.done),      32'd1);
    check("done_busy", 32'(bus.busy),      32'd0);
    check("done_addr", 32'(bus.mem_addr),  32'd0);
    check("done_wr",   32'(bus.mem_wr_en), 32'd0);

    // Reset on the 8th edge after start aborts a 0x0001 conversion.
    mem[0] = 8'h01;
    mem[1] = 8'h00;
    mem[2] = 8'h5a;
    mem[3] = 8'ha5;
    @(negedge clk);
    wr_cnt    = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_busy_mid", 32'(bus.busy), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_addr", 32'(bus.mem_addr), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_mem", 32'({mem[3], mem[2]}), 32'h0000a55a);
    check("abort_wr_pulses", 32'(wr_cnt), 32'd0);
    check("abort_done_late", 32'(bus.done), 32'd0);
    run_conv(16'h4000, 0, res, edges, pulses);
    check("post_abort_result", 32'(res), 32'h00005400);
    check("post_abort_edges", 32'(edges), 32'd6);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    check("rst_prio_busy", 32'(bus.busy), 32'd0);
    check("rst_prio_done", 32'(bus.done), 32'd0);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] in;
      in = 16'($urandom);
      if (i % 4 == 1) in = in >> (i % 13);
      model(in, mres, medges);
      run_conv(in, 0, res, edges, pulses);
      check($sformatf("rand%0d_result_in%04h", i, in), 32'(res), 32'(mres));
      check($sformatf("rand%0d_edges_in%04h", i, in), 32'(edges), 32'(medges));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
